// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: sequential unsigned magnitude comparator, two bits per clock, MSB first.
// Optional macro SEQ_MAG_CMP_EARLY_EXIT_EN finishes on the first unequal pair.
`default_nettype none

module seq_mag_cmp #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             agtb,
   output logic             aeqb,
   output logic             altb
);

   localparam int N  = WIDTH / 2;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_decided;
   logic             r_gt;
   logic             r_lt;
   logic             r_agtb;
   logic             r_aeqb;
   logic             r_altb;

   logic [1:0]       w_pa;
   logic [1:0]       w_pb;
   logic             w_pgt;
   logic             w_plt;
   logic             w_last;
   logic             w_gt_f;
   logic             w_lt_f;
   logic             w_finish;

   assign w_pa   = r_a[WIDTH-1 -: 2];
   assign w_pb   = r_b[WIDTH-1 -: 2];
   assign w_pgt  = (w_pa > w_pb);
   assign w_plt  = (w_pa < w_pb);
   assign w_last = (r_cnt == CW'(1));

   // A decision latched on an earlier pair outranks the current pair.
   assign w_gt_f = r_decided ? r_gt : w_pgt;
   assign w_lt_f = r_decided ? r_lt : w_plt;

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
   assign w_finish = w_last || w_pgt || w_plt;
`else
   assign w_finish = w_last;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_finish) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_decided <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
         r_agtb    <= 1'b0;
         r_aeqb    <= 1'b0;
         r_altb    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_cnt     <= CW'(N);
                  r_decided <= 1'b0;
                  r_gt      <= 1'b0;
                  r_lt      <= 1'b0;
               end
            end
            S_RUN: begin
               r_a   <= r_a << 2;
               r_b   <= r_b << 2;
               r_cnt <= r_cnt - CW'(1);
               if (!r_decided && (w_pgt || w_plt)) begin
                  r_decided <= 1'b1;
                  r_gt      <= w_pgt;
                  r_lt      <= w_plt;
               end
               if (w_finish) begin
                  r_agtb <= w_gt_f;
                  r_altb <= w_lt_f;
                  r_aeqb <= !(w_gt_f || w_lt_f);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign agtb = r_agtb;
   assign aeqb = r_aeqb;
   assign altb = r_altb;

endmodule

`default_nettype wire

// File: doc/seq_mag_cmp.md
SEQ_MAG_CMP -- requirements
Module: seq_mag_cmp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits; even, >= 2.
REQ-002 Ports SHALL be:
  clk      input   1      sole clock, rising-edge active
  reset_n  input   1      asynchronous, active-low reset
  start    input   1      request to compare a and b
  a        input   WIDTH  unsigned operand A
  b        input   WIDTH  unsigned operand B
  busy     output  1      comparison in progress
  done     output  1      one-cycle pulse; results newly valid
  agtb     output  1      A > B
  aeqb     output  1      A == B
  altb     output  1      A < B
REQ-003 The design SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL compare a and b MSB-first, two bits (one "pair") per clock, using a 2-bit greater/equal evaluation; N = WIDTH/2 pairs.
REQ-005 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-006 In IDLE with start=1 at a rising edge: a and b SHALL be captured into internal shift registers, pair counter = N, decided flag cleared, next state RUN.
REQ-007 In IDLE with start=0 the state SHALL be held.
REQ-008 In RUN, each edge SHALL evaluate the top pair of both registers, shift both registers left by 2 and decrement the counter.
REQ-009 In RUN, the first unequal pair SHALL set the decided flag and latch gt/lt; later pairs SHALL NOT change the latched decision.
REQ-010 RUN SHALL exit to DONE on the edge that processes pair N; agtb/aeqb/altb SHALL be written on that same edge.
REQ-011 aeqb=1 SHALL be produced only if all N pairs are equal.
REQ-012 Exactly one of agtb/aeqb/altb SHALL be 1 after the first completed comparison.
REQ-013 DONE SHALL assert done=1 for exactly one cycle and return to IDLE on the next edge.
REQ-014 With no early exit, done SHALL be high in the cycle following the Nth edge after the start-sampling edge.
REQ-015 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-016 start SHALL be ignored while busy=1; a/b changes after capture SHALL NOT affect the result.
REQ-017 Result outputs SHALL hold their value until the end of the next accepted comparison.
REQ-018 A start in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-019 For WIDTH=2 the comparison SHALL complete in one RUN edge.

Reset
REQ-020 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, agtb=0, aeqb=0, altb=0, counter=0 and shift registers=0.
REQ-021 Reset asserted mid-RUN SHALL abort the comparison with no done pulse; after release, the block SHALL accept start on the first edge.

Configuration
REQ-022 Macro SEQ_MAG_CMP_EARLY_EXIT_EN SHALL select early exit.
REQ-023 With SEQ_MAG_CMP_EARLY_EXIT_EN defined, RUN SHALL exit to DONE on the edge that finds the first unequal pair, writing results on that edge; the done latency is then j cycles, where j = index of that pair (1..N).
REQ-024 Equal operands SHALL still take N cycles when SEQ_MAG_CMP_EARLY_EXIT_EN is defined.
REQ-025 Without SEQ_MAG_CMP_EARLY_EXIT_EN, latency SHALL always be N cycles, per REQ-010.

Verification (WIDTH=8)
REQ-026 a=0xA5, b=0xA5, start pulse -> aeqb=1, done 4 cycles after the start edge, with or without the macro.
REQ-027 a=0x80, b=0x7F -> agtb=1; done after 1 cycle with SEQ_MAG_CMP_EARLY_EXIT_EN, 4 cycles without.
REQ-028 a=0x12, b=0x13 -> altb=1, done after 4 cycles in both builds; flags hold until the next start.
REQ-029 start re-pulsed with a=0xFF, b=0x00 while busy -> request ignored; the original result and timing are unchanged; busy=1 throughout.
REQ-030 reset_n low during the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; start after release gives a correct result.
REQ-031 WIDTH=2 instance, all 16 a/b combinations -> correct flag each time, done 1 cycle after start.
